// File: rtl/lms_pkg.sv
// Shared types for the LMS sequencer: FSM state encoding and datapath phase select.
package lms_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILT,
        FDRAIN,
        ERR,
        UPD,
        UDRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_FILT = 2'd1,
        PH_UPD  = 2'd2
    } phase_t;

endpackage

// File: rtl/lms_sequencer_if.sv
// Control/handshake bundle between the sample strobe, the LMS sequencer and the LMS datapath.
interface lms_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              ready_in;
    logic              adapt_en_in;
    logic              clr_ovr_in;
    logic              sample_wr_out;
    logic [ADDR_W-1:0] head_out;
    logic [ADDR_W-1:0] x_addr_out;
    logic [ADDR_W-1:0] w_addr_out;
    logic [1:0]        phase_out;
    logic              mac_clr_out;
    logic              mac_en_out;
    logic              err_latch_out;
    logic              y_valid_out;
    logic              w_we_out;
    logic [ADDR_W-1:0] w_wr_addr_out;
    logic              busy_out;
    logic              done_out;
    logic              overrun_out;

    modport master (
        output ready_in, adapt_en_in, clr_ovr_in,
        input  sample_wr_out, head_out, x_addr_out, w_addr_out, phase_out,
               mac_clr_out, mac_en_out, err_latch_out, y_valid_out,
               w_we_out, w_wr_addr_out, busy_out, done_out, overrun_out
    );

    modport slave (
        input  ready_in, adapt_en_in, clr_ovr_in,
        output sample_wr_out, head_out, x_addr_out, w_addr_out, phase_out,
               mac_clr_out, mac_en_out, err_latch_out, y_valid_out,
               w_we_out, w_wr_addr_out, busy_out, done_out, overrun_out
    );
endinterface

// File: rtl/lms_seq_delay.sv
// MAC_LAT-deep shift register of {valid, addr}: turns UPDATE issues into coefficient
// write-backs aligned with the MAC product.
module lms_seq_delay #(
    parameter int ADDR_W  = 5,
    parameter int MAC_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);
    logic [MAC_LAT-1:0]             r_valid;
    logic [MAC_LAT-1:0][ADDR_W-1:0] r_addr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
            r_addr  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int unsigned i = 1; i < MAC_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[MAC_LAT-1];
    assign o_addr  = r_addr[MAC_LAT-1];
endmodule

// File: rtl/lms_sequencer.sv
// LMS adaptive FIR control FSM: per sample strobe, runs FILTER, error capture and
// optional UPDATE through one shared MAC, with registered control outputs.
module lms_sequencer
    import lms_pkg::*;
#(
    parameter int NTAPS   = 32,
    parameter int ADDR_W  = 5,
    parameter int MAC_LAT = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    lms_sequencer_if.slave  bus
);
    localparam int CLAT = $clog2(MAC_LAT + 1);
    localparam int CW   = (ADDR_W > CLAT) ? ADDR_W : CLAT;
    localparam logic [CW-1:0] K_LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] D_LAST = CW'(MAC_LAT - 1);

    state_t            r_state;
    phase_t            r_phase;
    logic [CW-1:0]     r_k;
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_x_addr;
    logic [ADDR_W-1:0] r_w_addr;
    logic              r_sample_wr;
    logic              r_mac_clr;
    logic              r_mac_en;
    logic              r_err_latch;
    logic              r_y_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;

    logic [CW-1:0]     w_k_inc;
    logic [ADDR_W-1:0] w_k_addr;
    logic              w_drop;
    logic              w_upd_issue;
    logic              w_we;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_k_inc     = r_k + CW'(1);
    assign w_k_addr    = w_k_inc[ADDR_W-1:0];
    assign w_drop      = bus.ready_in && (r_state != IDLE) && (r_state != DONE);
    assign w_upd_issue = r_mac_en && (r_phase == PH_UPD);

    // Outputs are computed for the state being entered, so each lands in the same cycle as it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_phase     <= PH_IDLE;
            r_k         <= '0;
            r_head      <= '0;
            r_x_addr    <= '0;
            r_w_addr    <= '0;
            r_sample_wr <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_err_latch <= 1'b0;
            r_y_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sample_wr <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_err_latch <= 1'b0;
            r_y_valid   <= 1'b0;
            r_done      <= 1'b0;
            r_x_addr    <= '0;
            r_w_addr    <= '0;

            if (w_drop)
                r_overrun <= 1'b1;
            else if (bus.clr_ovr_in)
                r_overrun <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.ready_in) begin
                        r_state     <= LOAD;
                        r_sample_wr <= 1'b1;
                        r_mac_clr   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state  <= FILT;
                    r_phase  <= PH_FILT;
                    r_k      <= '0;
                    r_mac_en <= 1'b1;
                    r_x_addr <= r_head;
                end
                FILT, UPD: begin
                    if (r_k == K_LAST) begin
                        r_state <= (r_state == FILT) ? FDRAIN : UDRAIN;
                        r_k     <= '0;
                    end else begin
                        r_k      <= w_k_inc;
                        r_mac_en <= 1'b1;
                        r_x_addr <= r_head - w_k_addr;
                        r_w_addr <= w_k_addr;
                    end
                end
                FDRAIN: begin
                    if (r_k == D_LAST) begin
                        r_state     <= ERR;
                        r_phase     <= PH_IDLE;
                        r_k         <= '0;
                        r_y_valid   <= 1'b1;
                        r_err_latch <= 1'b1;
                    end else begin
                        r_k <= w_k_inc;
                    end
                end
                ERR: begin
                    if (bus.adapt_en_in) begin
                        r_state  <= UPD;
                        r_phase  <= PH_UPD;
                        r_k      <= '0;
                        r_mac_en <= 1'b1;
                        r_x_addr <= r_head;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                UDRAIN: begin
                    if (r_k == D_LAST) begin
                        r_state <= DONE;
                        r_phase <= PH_IDLE;
                        r_k     <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k <= w_k_inc;
                    end
                end
                DONE: begin
                    r_head <= r_head + ADDR_W'(1);
                    if (bus.ready_in) begin
                        r_state     <= LOAD;
                        r_sample_wr <= 1'b1;
                        r_mac_clr   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_phase <= PH_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    lms_seq_delay #(
        .ADDR_W  (ADDR_W),
        .MAC_LAT (MAC_LAT)
    ) u_delay (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_valid (w_upd_issue),
        .i_addr  (r_w_addr),
        .o_valid (w_we),
        .o_addr  (w_wr_addr)
    );

    assign bus.sample_wr_out = r_sample_wr;
    assign bus.head_out      = r_head;
    assign bus.x_addr_out    = r_x_addr;
    assign bus.w_addr_out    = r_w_addr;
    assign bus.phase_out     = r_phase;
    assign bus.mac_clr_out   = r_mac_clr;
    assign bus.mac_en_out    = r_mac_en;
    assign bus.err_latch_out = r_err_latch;
    assign bus.y_valid_out   = r_y_valid;
    assign bus.w_we_out      = w_we;
    assign bus.w_wr_addr_out = w_wr_addr;
    assign bus.busy_out      = r_busy;
    assign bus.done_out      = r_done;
    assign bus.overrun_out   = r_overrun;
endmodule

// File: tb/tb_lms_sequencer.sv
// Directed self-checking bench for lms_sequencer at NTAPS=32, ADDR_W=5, MAC_LAT=2.
module tb_lms_sequencer;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    lms_sequencer_if #(.ADDR_W(5)) bus ();

    lms_sequencer #(
        .NTAPS   (32),
        .ADDR_W  (5),
        .MAC_LAT (2)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Cycle t=1 is LOAD; returns while sitting in the DONE cycle.
    task automatic run_sample(input bit adapt, input logic [4:0] h0, input bit prestarted,
                              input int ovr_t, input string tag);
        int t_yv = -1;
        int t_done = -1;
        int fk = 0;
        int uk = 0;
        int nwe = 0;
        int n_sw = 0;
        int bad_x = 0;
        int bad_w = 0;
        bit ph2 = 1'b0;
        logic [4:0] ea;
        bus.adapt_en_in = adapt;
        if (!prestarted) begin
            bus.ready_in = 1'b1;
            cyc();
            bus.ready_in = 1'b0;
        end
        for (int t = 1; t <= 90 && t_done < 0; t++) begin
            if (bus.sample_wr_out) begin
                n_sw++;
                if (bus.head_out !== h0) bad_x++;
            end
            if (bus.y_valid_out) t_yv = t;
            if (bus.phase_out == 2'd2) ph2 = 1'b1;
            if (bus.mac_en_out) begin
                if (bus.phase_out == 2'd1) begin
                    ea = h0 - 5'(fk);
                    if (bus.x_addr_out !== ea || bus.w_addr_out !== 5'(fk)) bad_x++;
                    fk++;
                end else if (bus.phase_out == 2'd2) begin
                    ea = h0 - 5'(uk);
                    if (bus.x_addr_out !== ea || bus.w_addr_out !== 5'(uk)) bad_x++;
                    uk++;
                end else begin
                    bad_x++;
                end
            end
            if (bus.w_we_out) begin
                if (bus.phase_out !== 2'd2 || bus.w_wr_addr_out !== 5'(nwe) || t != 39 + nwe)
                    bad_w++;
                nwe++;
            end
            if (bus.done_out) begin
                t_done = t;
            end else begin
                if (t == ovr_t) begin
                    bus.ready_in   = 1'b1;
                    bus.clr_ovr_in = 1'b1;
                end
                cyc();
                bus.ready_in   = 1'b0;
                bus.clr_ovr_in = 1'b0;
            end
        end
        chk({tag, " y_valid cycle"}, t_yv, 36);
        chk({tag, " done cycle"}, t_done, adapt ? 71 : 37);
        chk({tag, " filt issues"}, fk, 32);
        chk({tag, " upd issues"}, uk, adapt ? 32 : 0);
        chk({tag, " w_we pulses"}, nwe, adapt ? 32 : 0);
        chk({tag, " phase2 seen"}, 32'(ph2), 32'(adapt));
        chk({tag, " sample_wr count"}, n_sw, 1);
        chk({tag, " addr errors"}, bad_x, 0);
        chk({tag, " writeback errors"}, bad_w, 0);
    endtask

    initial begin
        int nwe_rst;
        bus.ready_in    = 1'b0;
        bus.adapt_en_in = 1'b0;
        bus.clr_ovr_in  = 1'b0;
        repeat (3) cyc();
        chk("reset busy", 32'(bus.busy_out), 0);
        chk("reset head", 32'(bus.head_out), 0);
        chk("reset outs", 32'({bus.sample_wr_out, bus.mac_en_out, bus.mac_clr_out, bus.w_we_out,
                               bus.phase_out, bus.done_out, bus.y_valid_out, bus.overrun_out}), 0);
        rst_in = 1'b1;
        cyc();

        run_sample(1'b1, 5'd0, 1'b0, 0, "t1");
        cyc();
        chk("t1 head after", 32'(bus.head_out), 1);
        chk("t1 busy after", 32'(bus.busy_out), 0);

        run_sample(1'b0, 5'd1, 1'b0, 0, "t2");
        cyc();
        chk("t2 head after", 32'(bus.head_out), 2);
        run_sample(1'b0, 5'd2, 1'b0, 0, "t3pre");
        cyc();
        run_sample(1'b1, 5'd3, 1'b0, 0, "t3");
        cyc();
        chk("t3 head after", 32'(bus.head_out), 4);
        chk("t3 no overrun", 32'(bus.overrun_out), 0);

        // Dropped strobe at FILT k=10, with a simultaneous clear that must lose.
        run_sample(1'b1, 5'd4, 1'b0, 12, "t4");
        chk("t4 overrun set", 32'(bus.overrun_out), 1);
        cyc();
        bus.clr_ovr_in = 1'b1;
        cyc();
        bus.clr_ovr_in = 1'b0;
        chk("t4 overrun cleared", 32'(bus.overrun_out), 0);
        chk("t4 head after", 32'(bus.head_out), 5);

        run_sample(1'b1, 5'd5, 1'b0, 0, "t5a");
        bus.ready_in = 1'b1;
        cyc();
        bus.ready_in = 1'b0;
        chk("t5 sample_wr", 32'(bus.sample_wr_out), 1);
        chk("t5 new head", 32'(bus.head_out), 6);
        chk("t5 no overrun", 32'(bus.overrun_out), 0);
        run_sample(1'b1, 5'd6, 1'b1, 0, "t5b");
        cyc();
        chk("t5 head after", 32'(bus.head_out), 7);

        bus.adapt_en_in = 1'b1;
        bus.ready_in = 1'b1;
        cyc();
        bus.ready_in = 1'b0;
        repeat (48) cyc();
        chk("t6 upd phase", 32'(bus.phase_out), 2);
        chk("t6 upd k", 32'(bus.w_addr_out), 12);
        chk("t6 wb addr", 32'({bus.w_we_out, bus.w_wr_addr_out}), 32'({1'b1, 5'd10}));
        #2 rst_in = 1'b0;
        #1;
        chk("t6 async outs", 32'({bus.busy_out, bus.mac_en_out, bus.w_we_out, bus.phase_out,
                                  bus.head_out, bus.x_addr_out, bus.w_addr_out}), 0);
        nwe_rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.w_we_out) nwe_rst++;
        end
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.w_we_out) nwe_rst++;
        end
        chk("t6 no we after reset", nwe_rst, 0);
        run_sample(1'b1, 5'd0, 1'b0, 0, "t6 restart");
        cyc();
        chk("t6 head after", 32'(bus.head_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
